fifo_producer_arbiter: RTL and testbench

//   Round-robin arbiter that shares one FIFO production port between NUM_REQ producers.

---
 rtl/fifo_producer_arbiter.sv | 133 +++++++++++++
 tb/tb_fifo_producer_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_producer_arbiter.sv
// Round-robin arbiter that shares one FIFO write port between NUM_REQ valid/ready producers.
// Each grant lasts until the owner drains or BURST beats have moved. One idle cycle sits between grants.
module fifo_producer_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int BURST   = 16
) (
  input  logic                       clk_in,
  input  logic                       reset_in,
  input  logic [NUM_REQ*WIDTH-1:0]   reqData_in,
  input  logic [NUM_REQ-1:0]         reqValid_in,
  output logic [NUM_REQ-1:0]         reqReady_out,
  output logic [WIDTH-1:0]           outData_out,
  output logic                       outValid_out,
  input  logic                       outReady_in,
  output logic [NUM_REQ-1:0]         grant_out,
  output logic [7:0]                 beatCount_out
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(BURST + 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [IDX_W-1:0]   winner_idx;
  logic [NUM_REQ-1:0] winner_onehot;
  logic               any_req;
  logic               owner_valid;
  logic [WIDTH-1:0]   masked_data [NUM_REQ];

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a, input int unsigned b);
    int unsigned s;
    s = 32'(a) + b;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // Walk the offsets downward so the lowest offset from rr_ptr_q wins.
  always_comb begin
    winner_idx = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (reqValid_in[wrap_add(rr_ptr_q, j)]) winner_idx = wrap_add(rr_ptr_q, j);
    end
  end

  assign any_req = |reqValid_in;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign winner_onehot[gi] = (winner_idx == IDX_W'(gi));
      assign masked_data[gi]   = reqData_in[gi*WIDTH +: WIDTH] & {WIDTH{grant_q[gi]}};
    end
  endgenerate

  // Combinational pass-through; an all-zero grant (IDLE or reset) forces every output low.
  always_comb begin
    outData_out = '0;
    for (int i = 0; i < NUM_REQ; i++) outData_out = outData_out | masked_data[i];
  end

  assign owner_valid  = |(reqValid_in & grant_q);
  assign outValid_out = owner_valid;
  assign reqReady_out = grant_q & {NUM_REQ{outReady_in}};
  assign grant_out    = grant_q;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = OWNED;
          owner_d = winner_idx;
          grant_d = winner_onehot;
          count_d = '0;
        end
      end
      OWNED: begin
        if (!owner_valid) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = wrap_add(owner_q, 1);
        end else if (outReady_in) begin
          count_d = count_q + CNT_W'(1);
          if (count_q == CNT_W'(BURST - 1)) begin
            state_d  = IDLE;
            grant_d  = '0;
            rr_ptr_d = wrap_add(owner_q, 1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
    end
  end

  // A 256-beat burst needs a 9-bit counter; the 8-bit port shows 255 for the final value.
  generate
    if (CNT_W > 8) begin : g_cnt_sat
      assign beatCount_out = (count_q > CNT_W'(255)) ? 8'hFF : count_q[7:0];
    end else begin : g_cnt_ext
      assign beatCount_out = 8'(count_q);
    end
  endgenerate

endmodule

// File: tb/tb_fifo_producer_arbiter.sv
// Drives a BURST=16 and a BURST=1 arbiter from shared producers and checks both against a queue-level model.
module tb_fifo_producer_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] req_data;
  logic [3:0]  valid = 4'h0;
  logic        ready = 1'b0;

  logic [3:0]  rdy16, gnt16, rdy1, gnt1;
  logic [7:0]  od16, bc16, od1, bc1;
  logic        ov16, ov1;

  logic [5:0]  seq [4];
  logic [5:0]  sink_seq [4];
  logic [3:0]  acc;

  int n_vec = 0;
  int n_err = 0;

  bit m_owned [2];
  int m_owner [2];
  int m_ptr   [2];
  int m_count [2];
  bit nx_owned [2];
  int nx_owner [2];
  int nx_ptr   [2];
  int nx_count [2];
  int bst [2] = '{16, 1};

  fifo_producer_arbiter #(.NUM_REQ(4), .WIDTH(8), .BURST(16)) u_dut16 (
    .clk_in(clk), .reset_in(rst_n), .reqData_in(req_data), .reqValid_in(valid),
    .reqReady_out(rdy16), .outData_out(od16), .outValid_out(ov16), .outReady_in(ready),
    .grant_out(gnt16), .beatCount_out(bc16));

  fifo_producer_arbiter #(.NUM_REQ(4), .WIDTH(8), .BURST(1)) u_dut1 (
    .clk_in(clk), .reset_in(rst_n), .reqData_in(req_data), .reqValid_in(valid),
    .reqReady_out(rdy1), .outData_out(od1), .outValid_out(ov1), .outReady_in(ready),
    .grant_out(gnt1), .beatCount_out(bc1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_data();
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = {2'(i), seq[i]};
  endtask

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_owned[k] = 1'b0; m_owner[k] = 0; m_ptr[k] = 0; m_count[k] = 0;
    end
  endtask

  // Model: an owner streams until it drops valid or has moved its burst; idle picks the next valid from the pointer.
  task automatic m_next();
    for (int k = 0; k < 2; k++) begin
      nx_owned[k] = m_owned[k]; nx_owner[k] = m_owner[k];
      nx_ptr[k] = m_ptr[k]; nx_count[k] = m_count[k];
      if (!m_owned[k]) begin
        for (int j = 3; j >= 0; j--) begin
          if (valid[(m_ptr[k] + j) % 4]) begin
            nx_owned[k] = 1'b1; nx_owner[k] = (m_ptr[k] + j) % 4; nx_count[k] = 0;
          end
        end
      end else if (!valid[m_owner[k]]) begin
        nx_owned[k] = 1'b0; nx_ptr[k] = (m_owner[k] + 1) % 4;
      end else if (ready) begin
        nx_count[k] = m_count[k] + 1;
        if (nx_count[k] == bst[k]) begin
          nx_owned[k] = 1'b0; nx_ptr[k] = (m_owner[k] + 1) % 4;
        end
      end
    end
  endtask

  task automatic check_dut(input int k, input logic [3:0] gnt, input logic [3:0] rdy,
                           input logic ov, input logic [7:0] od, input logic [7:0] bc);
    logic [3:0] eg, er;
    logic       ev;
    logic [7:0] ed;
    int         o;
    eg = 4'h0; er = 4'h0; ev = 1'b0; ed = 8'h0; o = m_owner[k];
    if (m_owned[k]) begin
      eg = 4'(1 << o);
      ev = valid[o];
      er = ready ? eg : 4'h0;
      ed = req_data[o*8 +: 8];
    end
    chk(k == 0 ? "b16.grant" : "b1.grant", 32'(gnt), 32'(eg));
    chk(k == 0 ? "b16.ready" : "b1.ready", 32'(rdy), 32'(er));
    chk(k == 0 ? "b16.valid" : "b1.valid", 32'(ov), 32'(ev));
    chk(k == 0 ? "b16.data" : "b1.data", 32'(od), 32'(ed));
    chk(k == 0 ? "b16.count" : "b1.count", 32'(bc), 32'(m_count[k]));
  endtask

  initial begin : compare
    int p;
    m_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) m_reset();
      check_dut(0, gnt16, rdy16, ov16, od16, bc16);
      check_dut(1, gnt1, rdy1, ov1, od1, bc1);
      if (rst_n && ov16 && ready) begin
        p = int'(od16[7:6]);
        chk("sink.order", 32'(od16[5:0]), 32'(sink_seq[p]));
        sink_seq[p] = sink_seq[p] + 1'b1;
      end
      m_next();
      @(posedge clk);
      if (!rst_n) begin
        m_reset();
      end else begin
        for (int k = 0; k < 2; k++) begin
          m_owned[k] = nx_owned[k]; m_owner[k] = nx_owner[k];
          m_ptr[k] = nx_ptr[k]; m_count[k] = nx_count[k];
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    acc = rdy16 & valid;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (acc[i]) seq[i] = seq[i] + 1'b1;
    drive_data();
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n2;
    for (int i = 0; i < 4; i++) begin seq[i] = '0; sink_seq[i] = '0; end
    acc = 4'h0;
    drive_data();

    // Reset held with every producer requesting
    valid = 4'hF; ready = 1'b1;
    repeat (3) tick();
    chk("rst.grant", 32'(gnt16), 32'h0);
    #1;
    chk("rst.ready", 32'(rdy16), 32'h0);
    chk("rst.valid", 32'(ov16), 32'h0);
    chk("rst.data", 32'(od16), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rst.first_grant16", 32'(gnt16), 32'h1);
    chk("rst.first_grant1", 32'(gnt1), 32'h1);

    // Round robin, 16-beat grants with one idle cycle between
    for (int c = 0; c <= 68; c++) begin
      if (c % 17 == 0) chk("rr.grant", 32'(gnt16), 32'(1 << ((c / 17) % 4)));
      if (c % 17 == 16) begin
        chk("rr.idle_grant", 32'(gnt16), 32'h0);
        chk("rr.idle_count", 32'(bc16), 32'd16);
      end
      tick();
    end

    // Early release: producer 2 moves 5 beats then drops valid
    rst_n = 1'b0; valid = 4'h0;
    tick();
    rst_n = 1'b1; valid = 4'b0100;
    tick();
    chk("early.grant", 32'(gnt16), 32'h4);
    n2 = 0;
    for (int it = 0; it < 20 && n2 < 5; it++) begin
      tick();
      if (acc[2]) n2++;
    end
    chk("early.beats", 32'(n2), 32'd5);
    valid = 4'b1001;
    #1;
    chk("early.drop_valid", 32'(ov16), 32'h0);
    chk("early.held_grant", 32'(gnt16), 32'h4);
    chk("early.count", 32'(bc16), 32'd5);
    tick();
    chk("early.release", 32'(gnt16), 32'h0);
    chk("early.count_hold", 32'(bc16), 32'd5);
    tick();
    chk("early.next_grant", 32'(gnt16), 32'h8);
    chk("early.count_clear", 32'(bc16), 32'd0);

    // Back-pressure on owner 3
    repeat (3) tick();
    chk("bp.count_before", 32'(bc16), 32'd3);
    ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("bp.grant", 32'(gnt16), 32'h8);
      chk("bp.count", 32'(bc16), 32'd3);
      #1;
      chk("bp.ready", 32'(rdy16), 32'h0);
      chk("bp.valid", 32'(ov16), 32'h1);
    end
    ready = 1'b1;
    tick();
    chk("bp.resume_count", 32'(bc16), 32'd4);

    // BURST=1 with producers 0 and 1 always valid
    valid = 4'b0011; rst_n = 1'b0;
    #1;
    chk("b1.rst_grant", 32'(gnt1), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 0) begin
        chk("b1.alt_grant", 32'(gnt1), 32'(1 << ((k / 2) % 2)));
      end else begin
        chk("b1.alt_idle", 32'(gnt1), 32'h0);
        chk("b1.alt_count", 32'(bc1), 32'd1);
      end
      tick();
    end

    // Reset while beat 7 of producer 1 is pending
    rst_n = 1'b0; valid = 4'b0010;
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid.grant", 32'(gnt16), 32'h2);
    repeat (6) tick();
    chk("mid.count", 32'(bc16), 32'd6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid.async_grant", 32'(gnt16), 32'h0);
    chk("mid.async_ready", 32'(rdy16), 32'h0);
    chk("mid.async_valid", 32'(ov16), 32'h0);
    chk("mid.async_count", 32'(bc16), 32'h0);
    tick();
    rst_n = 1'b1; valid = 4'b0011;
    tick();
    chk("mid.regrant", 32'(gnt16), 32'h1);

    // Random traffic: sticky valids, random back-pressure, rare resets
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 9) == 0) valid[i] = ~valid[i];
      ready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 499) != 0);
      tick();
    end
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
